asg_seq_ctrl: RTL
=================

Name: asg_seq_ctrl

Overview:
- Per-channel segment sequencer for the double-buffered arbitrary signal generator.
- Steps the waveform generator through up to NSEG table segments, each played for a programmed number of table cycles.
- Repeats the full pass with an optional microsecond gap between passes.
- Owns the ping-pong bank select, so software refills the inactive buffer bank and the swap lands only on a pass boundary.

Parameters:
NSEG, 4, number of segment profiles
SW, 2, segment index width (log2 NSEG)
CW, 16, per-segment cycle-count width
US_TICKS, 125, dac_clk_i cycles per 1 us delay unit

Ports:
dac_clk_i  in  1  DAC clock
dac_rst_i  in  1  reset, synchronous, active-high
cfg_en_i  in  1  sequencer enable (level)
cfg_nseg_i  in  SW  index of last segment played (segments 0..cfg_nseg_i)
cfg_ncyc_i  in  NSEG*CW  cycles per segment, seg k at [k*CW +: CW]; 0 = infinite
cfg_nrep_i  in  16  extra passes after the first
cfg_loop_i  in  1  repeat passes forever
cfg_dly_i  in  32  gap between passes, 1 us units
trig_i  in  1  external trigger level, rising-edge sensitive
sw_trig_i  in  1  software trigger pulse
stop_i  in  1  abort pulse
swap_req_i  in  1  bank swap request pulse
cyc_end_i  in  1  generator pulse at each table wrap
seg_o  out  SW  active segment index
seg_start_o  out  1  one-cycle pulse: generator loads the segment's offset, size and step
run_o  out  1  generator enable
bank_o  out  1  active buffer bank
swap_ack_o  out  1  one-cycle pulse when bank_o toggles
trig_o  out  1  one-cycle pulse at sequence start
busy_o  out  1  high outside IDLE
done_o  out  1  one-cycle pulse at natural completion

Behaviour:
- Reset: every output is 0; FSM = IDLE; all counters, pending-swap flag and trigger edge register cleared. Reset during RUN or GAP takes effect on the next edge.
- Trigger detection: trig_i is registered. A rising edge is trig_i=1 at cycle N with trig_i=0 at N-1. sw_trig_i=1 at cycle N is equivalent.
- Triggers are honoured only in IDLE with cfg_en_i=1. In all other states they are ignored.
- FSM states: IDLE, RUN, GAP.
- IDLE -> RUN on a trigger at cycle N. At N+1: seg_o=0, seg_start_o=1, run_o=1, trig_o=1, busy_o=1. Cycle and repetition counters are zeroed.
- RUN:
  - Count cyc_end_i pulses against cfg_ncyc_i[seg].
  - When ncyc[seg]=0 the segment never ends.
  - When the pulse at cycle M makes count == ncyc[seg] and seg < cfg_nseg_i: at M+1, seg_o=seg+1, seg_start_o=1, cycle count cleared.
  - When seg == cfg_nseg_i at that boundary, the pass ends. See pass end.
- Pass end (cycle M):
  - If cfg_loop_i=1 or rep_cnt < cfg_nrep_i: rep_cnt increments.
    - If cfg_dly_i=0: at M+1 seg_o=0 and seg_start_o=1, with no gap.
    - Otherwise enter GAP with run_o=0 from M+1.
  - Else: at M+1 done_o=1, run_o=0, busy_o=0, state IDLE.
- GAP:
  - run_o=0 for exactly cfg_dly_i*US_TICKS cycles, using a prescaler plus a 32-bit us counter.
  - On the next cycle: seg_o=0, seg_start_o=1, run_o=1, state RUN.
  - cyc_end_i is ignored in GAP.
- Stop:
  - stop_i=1, or cfg_en_i=0 while busy, at cycle M: at M+1 the FSM is in IDLE and run_o=0.
  - No done_o or seg_start_o is produced.
  - Stop has priority over a boundary or gap expiry in the same cycle.
- Bank swap:
  - swap_req_i sets a pending flag; repeat requests while pending are absorbed.
  - In IDLE: at the next cycle bank_o toggles and swap_ack_o=1.
  - While busy: the toggle is applied at the M+1 of a pass end, together with the restart seg_start_o or done_o.
  - A swap_req_i coinciding with a pass end is applied at that same boundary.
  - Stop clears nothing; a pending swap then completes in IDLE on the next cycle.
- Counter widths:
  - Cycle count is CW bits, compared for equality.
  - rep_cnt is 16 bits and does not wrap in loop mode: it saturates and is not compared.
  - cfg_* inputs are sampled live; software changes them only in IDLE, except cfg_dly_i, which is sampled on GAP entry.

Decomposition:
- Package asg_seq_pkg holds the FSM state enum (IDLE, RUN, GAP) and the US_TICKS default constant.
- One sub-module, asg_us_timer: prescaler plus microsecond down-counter with load, start and expire pulse.

Test Plan:
1. nseg=1, ncyc={2,3}, nrep=0, dly=0; trig rise at N; cyc_end every 10 clk -> seg_start at N+1 (seg 0); seg 0->1 the cycle after the 2nd pulse; done_o the cycle after the 5th pulse; run_o low thereafter.
2. nseg=0, ncyc={1}, nrep=2, dly=1 -> 3 passes; run_o low for exactly 125 clk between passes; trig_o once; done_o once after the 3rd cyc_end.
3. swap_req mid-pass with nseg=1 -> bank_o toggles and swap_ack_o pulses at the pass-end cycle+1. swap_req in IDLE -> toggle on the next cycle. Two requests while pending -> a single toggle.
4. stop_i in the same cycle as a segment boundary -> next cycle IDLE, run_o=0, no seg_start_o, no done_o.
5. ncyc[0]=0 -> 1000 cyc_end pulses leave seg_o=0; a retrigger in RUN is ignored; cfg_en_i drop -> IDLE next cycle.
6. dac_rst_i asserted during GAP -> next cycle all outputs 0, bank_o=0; a subsequent trigger starts cleanly at seg 0.

Source files
------------

// File: rtl/asg_seq_pkg.sv
// rtl/asg_seq_pkg.sv - shared state encoding and constants for the ASG segment sequencer
package asg_seq_pkg;

  // dac_clk_i cycles per microsecond at the nominal DAC rate
  localparam int US_TICKS_DEF = 125;

  typedef logic [1:0] seq_state_t;

  localparam seq_state_t ST_IDLE = 2'd0;
  localparam seq_state_t ST_RUN  = 2'd1;
  localparam seq_state_t ST_GAP  = 2'd2;

  // Pass counter sticks at all-ones in loop mode instead of wrapping
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/asg_us_timer.sv
// rtl/asg_us_timer.sv - microsecond gap timer: prescaler plus down-counter with expire pulse
module asg_us_timer
  import asg_seq_pkg::*;
#(
  parameter int US_TICKS = US_TICKS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        clr,
  input  logic [31:0] load,
  output logic        expire
);

  localparam int PW = (US_TICKS > 1) ? $clog2(US_TICKS) : 1;
  localparam logic [PW-1:0] PRE_TOP = PW'(US_TICKS - 1);

  logic          active;
  logic [PW-1:0] pre_q;
  logic [31:0]   us_q;

  // Final cycle of the programmed window: last tick of the last microsecond
  assign expire = active && (pre_q == '0) && (us_q == 32'd1);

  // Prescaler counts down one microsecond, then the us counter steps down
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      active <= 1'b0;
      pre_q  <= '0;
      us_q   <= '0;
    end else if (start) begin
      active <= (load != 32'd0);
      pre_q  <= PRE_TOP;
      us_q   <= load;
    end else if (active) begin
      if (expire) begin
        active <= 1'b0;
      end
      if (pre_q == '0) begin
        pre_q <= PRE_TOP;
        us_q  <= us_q - 32'd1;
      end else begin
        pre_q <= pre_q - PW'(1);
      end
    end
  end

endmodule

// File: rtl/asg_seq_ctrl.sv
// rtl/asg_seq_ctrl.sv - per-channel segment sequencer with pass repeat, gap and bank swap
module asg_seq_ctrl
  import asg_seq_pkg::*;
#(
  parameter int NSEG     = 4,
  parameter int SW       = 2,
  parameter int CW       = 16,
  parameter int US_TICKS = US_TICKS_DEF
) (
  input  logic               dac_clk_i,
  input  logic               dac_rst_i,
  input  logic               cfg_en_i,
  input  logic [SW-1:0]      cfg_nseg_i,
  input  logic [NSEG*CW-1:0] cfg_ncyc_i,
  input  logic [15:0]        cfg_nrep_i,
  input  logic               cfg_loop_i,
  input  logic [31:0]        cfg_dly_i,
  input  logic               trig_i,
  input  logic               sw_trig_i,
  input  logic               stop_i,
  input  logic               swap_req_i,
  input  logic               cyc_end_i,
  output logic [SW-1:0]      seg_o,
  output logic               seg_start_o,
  output logic               run_o,
  output logic               bank_o,
  output logic               swap_ack_o,
  output logic               trig_o,
  output logic               busy_o,
  output logic               done_o
);

  seq_state_t    state_q;
  logic [CW-1:0] cyc_cnt_q;
  logic [15:0]   rep_cnt_q;
  logic          swap_pend_q;
  logic          trig_q;

  logic [CW-1:0] ncyc_cur;
  logic          trig_ev;
  logic          abort;
  logic          seg_done;
  logic          last_seg;
  logic          rep_more;
  logic          swap_now;
  logic          gap_start;
  logic          timer_expire;
  logic          gap_expire;

  assign busy_o    = (state_q != ST_IDLE);
  assign ncyc_cur  = cfg_ncyc_i[int'(seg_o) * CW +: CW];
  assign trig_ev   = cfg_en_i && ((trig_i && !trig_q) || sw_trig_i);
  // Stop or enable drop only matters while a sequence is active
  assign abort     = busy_o && (stop_i || !cfg_en_i);
  // A zero cycle count means the segment plays until stopped
  assign seg_done  = (state_q == ST_RUN) && cyc_end_i && (ncyc_cur != '0) &&
                     ((cyc_cnt_q + CW'(1)) == ncyc_cur);
  assign last_seg  = (seg_o >= cfg_nseg_i);
  assign rep_more  = cfg_loop_i || (rep_cnt_q < cfg_nrep_i);
  assign swap_now  = swap_pend_q || swap_req_i;
  assign gap_start = seg_done && last_seg && !abort && rep_more && (cfg_dly_i != 32'd0);
  assign gap_expire = (state_q == ST_GAP) && timer_expire;

  asg_us_timer #(
    .US_TICKS(US_TICKS)
  ) u_gap_timer (
    .clk    (dac_clk_i),
    .rst    (dac_rst_i),
    .start  (gap_start),
    .clr    (abort),
    .load   (cfg_dly_i),
    .expire (timer_expire)
  );

  // Sequencer FSM: trigger in IDLE, segment stepping in RUN, timed pause in GAP
  always_ff @(posedge dac_clk_i) begin
    if (dac_rst_i) begin
      state_q     <= ST_IDLE;
      cyc_cnt_q   <= '0;
      rep_cnt_q   <= '0;
      swap_pend_q <= 1'b0;
      trig_q      <= 1'b0;
      seg_o       <= '0;
      seg_start_o <= 1'b0;
      run_o       <= 1'b0;
      bank_o      <= 1'b0;
      swap_ack_o  <= 1'b0;
      trig_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      seg_start_o <= 1'b0;
      swap_ack_o  <= 1'b0;
      trig_o      <= 1'b0;
      done_o      <= 1'b0;
      trig_q      <= trig_i;

      if (state_q == ST_IDLE) begin
        // Idle bank is not being read, so a swap lands immediately
        if (swap_now) begin
          bank_o      <= ~bank_o;
          swap_ack_o  <= 1'b1;
          swap_pend_q <= 1'b0;
        end
        if (trig_ev) begin
          state_q     <= ST_RUN;
          seg_o       <= '0;
          cyc_cnt_q   <= '0;
          rep_cnt_q   <= '0;
          seg_start_o <= 1'b1;
          run_o       <= 1'b1;
          trig_o      <= 1'b1;
        end
      end else begin
        swap_pend_q <= swap_now;
        if (abort) begin
          state_q <= ST_IDLE;
          run_o   <= 1'b0;
        end else if (state_q == ST_RUN) begin
          if (cyc_end_i) begin
            cyc_cnt_q <= cyc_cnt_q + CW'(1);
          end
          if (seg_done) begin
            cyc_cnt_q <= '0;
            if (!last_seg) begin
              seg_o       <= seg_o + SW'(1);
              seg_start_o <= 1'b1;
            end else begin
              // Pass boundary: the only point where the playing bank may change
              if (swap_now) begin
                bank_o      <= ~bank_o;
                swap_ack_o  <= 1'b1;
                swap_pend_q <= 1'b0;
              end
              if (rep_more) begin
                rep_cnt_q <= sat_inc16(rep_cnt_q);
                if (cfg_dly_i == 32'd0) begin
                  seg_o       <= '0;
                  seg_start_o <= 1'b1;
                end else begin
                  state_q <= ST_GAP;
                  run_o   <= 1'b0;
                end
              end else begin
                state_q <= ST_IDLE;
                run_o   <= 1'b0;
                done_o  <= 1'b1;
              end
            end
          end
        end else if (state_q == ST_GAP) begin
          if (gap_expire) begin
            state_q     <= ST_RUN;
            seg_o       <= '0;
            cyc_cnt_q   <= '0;
            seg_start_o <= 1'b1;
            run_o       <= 1'b1;
          end
        end else begin
          state_q <= ST_IDLE;
          run_o   <= 1'b0;
        end
      end
    end
  end

endmodule
